// File: rtl/vga_timing_detect.sv
// rtl/vga_timing_detect.sv - raster geometry measurement, lock detection and coordinate regeneration
// Measures line/frame geometry from sync and blank inputs, locks on stable frames, regenerates x/y/de.
module vga_timing_detect #(
   parameter int CW          = 12,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT     = 4095
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          hsync,
   input  logic          vsync,
   input  logic          hblnk,
   input  logic          vblnk,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] h_active,
   output logic [CW-1:0] h_sync_width,
   output logic [CW-1:0] v_total,
   output logic [CW-1:0] v_active,
   output logic [CW-1:0] v_sync_width,
   output logic          locked,
   output logic [CW-1:0] x_pos,
   output logic [CW-1:0] y_pos,
   output logic          de
);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int MW = $clog2(LOCK_FRAMES + 1);
   localparam logic [CW-1:0] CMAX    = {CW{1'b1}};
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   function automatic logic [CW-1:0] inc(input logic [CW-1:0] v, input logic en);
      return (en && v != CMAX) ? v + CW'(1) : v;
   endfunction

   logic          hb_q, vb_q;
   logic [CW-1:0] s_cnt, a_cnt, h_cnt;
   logic [CW-1:0] ref_tot, ref_act, ref_hs;
   logic [CW-1:0] lc, lac, lsc;
   logic          bad;
   logic [6*CW-1:0] prev_v;
   logic          have_prev;
   logic [1:0]    state;
   logic [MW-1:0] match_cnt;
   logic [TW-1:0] to_cnt;

   logic          line_edge, frame_edge, first_line, line_bad, bad_n;
   logic          frame_match, timeout;
   logic [CW-1:0] ref_tot_n, ref_act_n, ref_hs_n;
   logic [CW-1:0] lc_n, lac_n, lsc_n, x_n, y_n;
   logic [6*CW-1:0] frame_v;
   logic [MW-1:0] match_inc;

   // A line closes on the edge that also opens the next frame, so frame totals include it.
   always_comb begin
      line_edge   = hb_q & ~hblnk;
      frame_edge  = vb_q & ~vblnk;
      first_line  = (lc == '0);
      ref_tot_n   = ref_tot;
      ref_act_n   = ref_act;
      ref_hs_n    = ref_hs;
      if (line_edge && first_line) begin
         ref_tot_n = s_cnt;
         ref_act_n = a_cnt;
         ref_hs_n  = h_cnt;
      end
      line_bad    = line_edge & ~first_line &
                    ({s_cnt, a_cnt, h_cnt} != {ref_tot, ref_act, ref_hs});
      bad_n       = bad | line_bad;
      lc_n        = inc(lc, line_edge);
      lac_n       = inc(lac, line_edge & ~vblnk);
      lsc_n       = inc(lsc, line_edge & vsync);
      frame_v     = {ref_tot_n, ref_act_n, ref_hs_n, lc_n, lac_n, lsc_n};
      frame_match = have_prev & ~bad_n & (frame_v == prev_v);
      timeout     = ~line_edge & (to_cnt == TO_LAST);
      x_n         = line_edge ? '0 : s_cnt;
      y_n         = frame_edge ? '0 : lc_n;
      match_inc   = match_cnt + MW'(1);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         hb_q <= 1'b0;  vb_q <= 1'b0;
         s_cnt <= '0;   a_cnt <= '0;   h_cnt <= '0;
         ref_tot <= '0; ref_act <= '0; ref_hs <= '0;
         lc <= '0;      lac <= '0;     lsc <= '0;
         bad <= 1'b0;   prev_v <= '0;  have_prev <= 1'b0;
         state <= ST_SEARCH; match_cnt <= '0; to_cnt <= '0;
         h_total <= '0; h_active <= '0; h_sync_width <= '0;
         v_total <= '0; v_active <= '0; v_sync_width <= '0;
         locked <= 1'b0; x_pos <= '0; y_pos <= '0; de <= 1'b0;
      end else begin
         hb_q <= hblnk;
         vb_q <= vblnk;
         if (line_edge) begin
            s_cnt <= CW'(1);
            a_cnt <= CW'(1);
            h_cnt <= {{(CW-1){1'b0}}, hsync};
         end else begin
            s_cnt <= inc(s_cnt, 1'b1);
            a_cnt <= inc(a_cnt, ~hblnk);
            h_cnt <= inc(h_cnt, hsync);
         end
         ref_tot <= ref_tot_n;
         ref_act <= ref_act_n;
         ref_hs  <= ref_hs_n;
         if (frame_edge) begin
            lc <= '0; lac <= '0; lsc <= '0; bad <= 1'b0;
         end else begin
            lc <= lc_n; lac <= lac_n; lsc <= lsc_n; bad <= bad_n;
         end
         to_cnt <= (line_edge || timeout) ? '0 : to_cnt + TW'(1);
         x_pos  <= locked ? x_n : '0;
         y_pos  <= locked ? y_n : '0;
         de     <= locked & ~hblnk & ~vblnk;

         if (timeout) begin
            state <= ST_SEARCH; locked <= 1'b0; match_cnt <= '0; have_prev <= 1'b0;
            h_total <= '0; h_active <= '0; h_sync_width <= '0;
            v_total <= '0; v_active <= '0; v_sync_width <= '0;
         end else if (frame_edge) begin
            if (state == ST_SEARCH) begin
               state     <= ST_MEASURE;
               match_cnt <= '0;
               have_prev <= 1'b0;
            end else begin
               {h_total, h_active, h_sync_width, v_total, v_active, v_sync_width} <= frame_v;
               prev_v    <= frame_v;
               // A bad frame cannot serve as history, so the next pair also mismatches.
               have_prev <= ~bad_n;
               if (!frame_match) begin
                  state     <= ST_MEASURE;
                  match_cnt <= '0;
                  locked    <= 1'b0;
               end else if (state != ST_LOCKED) begin
                  match_cnt <= match_inc;
                  if (match_inc >= MW'(LOCK_FRAMES)) begin
                     state  <= ST_LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_detect.sv
// tb/tb_vga_timing_detect.sv - randomized raster bench with a queue-based reference model
// Drives rasters of random geometry plus directed disturbances and compares every cycle.
module tb_vga_timing_detect;
   localparam int CW          = 12;
   localparam int LOCK_FRAMES = 2;
   localparam int TIMEOUT     = 4095;
   localparam int CMAX        = (1 << CW) - 1;
   localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

   logic pclk = 1'b0;
   logic rst, hsync, vsync, hblnk, vblnk;
   logic [CW-1:0] h_total, h_active, h_sync_width, v_total, v_active, v_sync_width;
   logic [CW-1:0] x_pos, y_pos;
   logic locked, de;

   vga_timing_detect #(.CW(CW), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
      .h_total(h_total), .h_active(h_active), .h_sync_width(h_sync_width),
      .v_total(v_total), .v_active(v_active), .v_sync_width(v_sync_width),
      .locked(locked), .x_pos(x_pos), .y_pos(y_pos), .de(de)
   );

   always #5 pclk = ~pclk;

   int tests = 0, fails = 0;
   int ht, ha, hss, hsw, vt, va, vss, vsw;
   int px, py, s_px = -1, s_py = -1, stretch_row = -1, falls = 0;
   bit frozen = 1'b0, drv_pvb = 1'b0;

   typedef struct { int tot; int act; int hs; } line_t;
   bit    q_hb[$];
   bit    q_hs[$];
   line_t f_lines[$];
   bit    f_act[$];
   bit    f_vs[$];
   bit    m_phb, m_pvb, m_prev_ok;
   int    m_mode, m_pairs, m_since;
   int    m_prev[6];
   int    e_meas[6];
   bit    e_locked, e_de;
   int    e_x, e_y;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q_hb.delete(); q_hs.delete(); f_lines.delete(); f_act.delete(); f_vs.delete();
      m_phb = 0; m_pvb = 0; m_prev_ok = 0; m_mode = M_SEARCH; m_pairs = 0; m_since = 0;
      for (int i = 0; i < 6; i++) begin m_prev[i] = 0; e_meas[i] = 0; end
      e_locked = 0; e_de = 0; e_x = 0; e_y = 0;
   endtask

   // Reference: a line is the list of samples between hblnk falls, a frame the list of lines between vblnk falls.
   task automatic model_sample(input bit hb, input bit vb, input bit hs, input bit vs);
      bit lb, fb, was_locked, bad, match;
      int x_now, y_now, nact, nvs;
      int rec[6];
      line_t l;
      lb = m_phb && !hb;
      fb = m_pvb && !vb;
      was_locked = e_locked;
      x_now = lb ? 0 : sat(q_hb.size());
      if (lb) begin
         l.tot = sat(q_hb.size()); l.act = 0; l.hs = 0;
         foreach (q_hb[i]) begin
            if (!q_hb[i]) l.act++;
            if (q_hs[i]) l.hs++;
         end
         l.act = sat(l.act); l.hs = sat(l.hs);
         f_lines.push_back(l); f_act.push_back(!vb); f_vs.push_back(vs);
         q_hb.delete(); q_hs.delete();
      end
      q_hb.push_back(hb); q_hs.push_back(hs);
      y_now = fb ? 0 : sat(f_lines.size());
      m_since = lb ? 0 : m_since + 1;
      if (fb) begin
         bad = 0; nact = 0; nvs = 0;
         for (int i = 0; i < 6; i++) rec[i] = 0;
         if (f_lines.size() > 0) begin
            rec[0] = f_lines[0].tot; rec[1] = f_lines[0].act; rec[2] = f_lines[0].hs;
         end
         foreach (f_lines[i])
            if (f_lines[i].tot != rec[0] || f_lines[i].act != rec[1] || f_lines[i].hs != rec[2]) bad = 1;
         foreach (f_act[i]) if (f_act[i]) nact++;
         foreach (f_vs[i]) if (f_vs[i]) nvs++;
         rec[3] = sat(f_lines.size()); rec[4] = sat(nact); rec[5] = sat(nvs);
         if (m_mode == M_SEARCH) begin
            m_mode = M_MEASURE; m_prev_ok = 0; m_pairs = 0;
         end else begin
            match = m_prev_ok && !bad;
            for (int i = 0; i < 6; i++) begin
               if (rec[i] != m_prev[i]) match = 0;
               m_prev[i] = rec[i];
               e_meas[i] = rec[i];
            end
            m_prev_ok = !bad;
            m_pairs = match ? m_pairs + 1 : 0;
            if (!match) m_mode = M_MEASURE;
            else if (m_pairs >= LOCK_FRAMES) m_mode = M_LOCKED;
            e_locked = (m_mode == M_LOCKED);
         end
         f_lines.delete(); f_act.delete(); f_vs.delete();
      end
      if (m_since == TIMEOUT) begin
         m_since = 0; m_mode = M_SEARCH; m_pairs = 0; m_prev_ok = 0; e_locked = 0;
         for (int i = 0; i < 6; i++) e_meas[i] = 0;
      end
      e_de = was_locked && !hb && !vb;
      e_x  = was_locked ? x_now : 0;
      e_y  = was_locked ? y_now : 0;
      m_phb = hb; m_pvb = vb;
   endtask

   task automatic step(input bit r);
      bit hb, vb, hs, vs;
      int len;
      len = (py == stretch_row) ? ht + 1 : ht;
      if (frozen) begin
         hb = 0; vb = 0; hs = 0; vs = 0;
      end else begin
         hb = (px >= ha); hs = (px >= hss) && (px < hss + hsw);
         vb = (py >= va); vs = (py >= vss) && (py < vss + vsw);
      end
      s_px = px; s_py = py;
      rst = r; hblnk = hb; vblnk = vb; hsync = hs; vsync = vs;
      if (r) model_reset();
      else model_sample(hb, vb, hs, vs);
      if (drv_pvb && !vb) falls++;
      drv_pvb = vb;
      @(posedge pclk);
      @(negedge pclk);
      check("meas", {locked, h_total, h_active, h_sync_width, v_total, v_active, v_sync_width},
            {e_locked, CW'(e_meas[0]), CW'(e_meas[1]), CW'(e_meas[2]),
             CW'(e_meas[3]), CW'(e_meas[4]), CW'(e_meas[5])});
      check("coord", {de, x_pos, y_pos}, {e_de, CW'(e_x), CW'(e_y)});
      if (!frozen) begin
         px++;
         if (px >= len) begin
            px = 0; py++;
            if (py >= vt) py = 0;
         end
      end
   endtask

   task automatic run_falls(input int n);
      int budget;
      falls = 0;
      budget = (n + 1) * vt * (ht + 1) + 16;
      while (falls < n && budget > 0) begin
         step(1'b0);
         budget--;
      end
      check("vblnk_falls", falls, n);
   endtask

   task automatic goto_sample(input int x, input int y);
      int budget;
      budget = vt * (ht + 1) + 16;
      while (!(s_px == x && s_py == y) && budget > 0) begin
         step(1'b0);
         budget--;
      end
      if (budget == 0) check("goto_budget", budget, 1);
   endtask

   task automatic new_geom();
      int hbl, vbl;
      ha  = $urandom_range(8, 30);  hbl = $urandom_range(4, 12); ht = ha + hbl;
      hss = ha + $urandom_range(0, hbl - 2); hsw = $urandom_range(1, ht - hss);
      va  = $urandom_range(4, 12);  vbl = $urandom_range(2, 6);  vt = va + vbl;
      vss = va + $urandom_range(0, vbl - 1); vsw = $urandom_range(1, vt - vss);
   endtask

   task automatic do_reset();
      frozen = 0; stretch_row = -1;
      repeat (3) step(1'b1);
      px = 0; py = 0; drv_pvb = 0;
      check("rst_locked", locked, 0);
      check("rst_h_total", h_total, 0);
   endtask

   task automatic check_geom(input string tag);
      check({tag, "_h_total"}, h_total, ht);
      check({tag, "_h_active"}, h_active, ha);
      check({tag, "_h_sync"}, h_sync_width, hsw);
      check({tag, "_v_total"}, v_total, vt);
      check({tag, "_v_active"}, v_active, va);
      check({tag, "_v_sync"}, v_sync_width, vsw);
   endtask

   initial begin
      int blank_de;
      rst = 1; hsync = 0; vsync = 0; hblnk = 0; vblnk = 0;
      model_reset();
      ht = 20; ha = 12; hss = 14; hsw = 3; vt = 10; va = 6; vss = 7; vsw = 1;
      px = 0; py = 0;

      for (int g = 0; g < 3; g++) begin
         new_geom();
         do_reset();
         run_falls(3); check("lock_not_yet", locked, 0);
         run_falls(1); check("lock_4th_fall", locked, 1);
         check_geom("lock");
      end

      stretch_row = $urandom_range(1, vt - 1);
      run_falls(1); stretch_row = -1;
      check("stretch_unlock", locked, 0);
      run_falls(2); check("stretch_no_early_relock", locked, 0);
      run_falls(1); check("stretch_relock", locked, 1);

      goto_sample(0, 1);
      frozen = 1;
      repeat (TIMEOUT - 200) step(1'b0);
      check("pre_timeout_locked", locked, 1);
      repeat (400) step(1'b0);
      check("timeout_locked", locked, 0);
      check("timeout_h_total", h_total, 0);
      check("timeout_v_total", v_total, 0);
      frozen = 0; px = 0; py = 0;
      run_falls(3); check("resume_not_yet", locked, 0);
      run_falls(1); check("resume_relock", locked, 1);

      run_falls(1);
      check("first_de", de, 1); check("first_x", x_pos, 0); check("first_y", y_pos, 0);
      goto_sample(ha - 1, va - 1);
      check("last_de", de, 1); check("last_x", x_pos, ha - 1); check("last_y", y_pos, va - 1);
      blank_de = 0;
      for (int b = 0; b < vt * ht && falls == 0; b++) begin
         if (b == 0) falls = 0;
         step(1'b0);
         if ((s_px >= ha || s_py >= va) && de) blank_de++;
      end
      check("blank_de", blank_de, 0);

      goto_sample(ha / 2, 1);
      step(1'b1);
      check("midline_rst_locked", locked, 0);
      check("midline_rst_x", x_pos, 0);
      check("midline_rst_de", de, 0);
      check("midline_rst_v_total", v_total, 0);
      run_falls(3); check("rst_relock_not_yet", locked, 0);
      run_falls(1); check("rst_relock", locked, 1);

      ht = 20; ha = 12; hss = 14; hsw = 3; vt = 10; va = 6; vss = 7; vsw = 1;
      do_reset();
      run_falls(4); check("small_locked", locked, 1);
      check_geom("small");
      run_falls(2); check("small_hold", locked, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
